// File: rtl/axil_split_dec.sv
// AXI-lite 1-to-N splitter with built-in address decode and DECERR slave.
// Ports: clk, rst_n, src_axi_* (master side), dst_axi_* [NUM_DSTS] (slaves).
module axil_split_dec #(
  parameter int NUM_DSTS        = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_DSTS-1:0][ADDR_WIDTH-1:0] DST_BASE = '0,
  parameter logic [NUM_DSTS-1:0][ADDR_WIDTH-1:0] DST_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] src_axi_awaddr,
  input  logic                  src_axi_awvalid,
  output logic                  src_axi_awready,
  input  logic [DATA_WIDTH-1:0] src_axi_wdata,
  input  logic [STRB_WIDTH-1:0] src_axi_wstrb,
  input  logic                  src_axi_wvalid,
  output logic                  src_axi_wready,
  output logic [1:0]            src_axi_bresp,
  output logic                  src_axi_bvalid,
  input  logic                  src_axi_bready,
  input  logic [ADDR_WIDTH-1:0] src_axi_araddr,
  input  logic                  src_axi_arvalid,
  output logic                  src_axi_arready,
  output logic [DATA_WIDTH-1:0] src_axi_rdata,
  output logic [1:0]            src_axi_rresp,
  output logic                  src_axi_rvalid,
  input  logic                  src_axi_rready,
  output logic [NUM_DSTS-1:0][ADDR_WIDTH-1:0] dst_axi_awaddr,
  output logic [NUM_DSTS-1:0]                 dst_axi_awvalid,
  input  logic [NUM_DSTS-1:0]                 dst_axi_awready,
  output logic [NUM_DSTS-1:0][DATA_WIDTH-1:0] dst_axi_wdata,
  output logic [NUM_DSTS-1:0][STRB_WIDTH-1:0] dst_axi_wstrb,
  output logic [NUM_DSTS-1:0]                 dst_axi_wvalid,
  input  logic [NUM_DSTS-1:0]                 dst_axi_wready,
  input  logic [NUM_DSTS-1:0][1:0]            dst_axi_bresp,
  input  logic [NUM_DSTS-1:0]                 dst_axi_bvalid,
  output logic [NUM_DSTS-1:0]                 dst_axi_bready,
  output logic [NUM_DSTS-1:0][ADDR_WIDTH-1:0] dst_axi_araddr,
  output logic [NUM_DSTS-1:0]                 dst_axi_arvalid,
  input  logic [NUM_DSTS-1:0]                 dst_axi_arready,
  input  logic [NUM_DSTS-1:0][DATA_WIDTH-1:0] dst_axi_rdata,
  input  logic [NUM_DSTS-1:0][1:0]            dst_axi_rresp,
  input  logic [NUM_DSTS-1:0]                 dst_axi_rvalid,
  output logic [NUM_DSTS-1:0]                 dst_axi_rready
);

  localparam int TW = $clog2(NUM_DSTS + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] ERR = TW'(NUM_DSTS);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

  // Lowest matching index wins; no match routes to the error slave.
  function automatic logic [TW-1:0] dec(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [TW-1:0] t;
    t = ERR;
    for (int i = NUM_DSTS - 1; i >= 0; i--) begin
      if ((a & DST_MASK[i]) ==
          (DST_BASE[i] & DST_MASK[i]))
        t = TW'(i);
    end
    return t;
  endfunction

  logic [TW-1:0] wr_tgt, rd_tgt;
  logic [TW-1:0] aw_tgt, ar_tgt;
  logic [CW-1:0] aw_cnt, w_owed, ar_cnt;

  logic aw_ok, ar_ok;
  logic w_sel, b_sel, r_sel;
  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [1:0] b_rsp, r_rsp;
  logic [DATA_WIDTH-1:0] r_dat;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_tgt = dec(src_axi_awaddr);
  assign ar_tgt = dec(src_axi_araddr);

  // All outstanding writes (reads) share one target, so the
  // responses come back in issue order without an ID FIFO.
  assign aw_ok = (aw_cnt < MAXC) &&
                 ((aw_cnt == '0) || (aw_tgt == wr_tgt));
  assign ar_ok = (ar_cnt < MAXC) &&
                 ((ar_cnt == '0) || (ar_tgt == rd_tgt));

  assign w_sel = (w_owed != '0);
  assign b_sel = (aw_cnt != '0);
  assign r_sel = (ar_cnt != '0);

  always_comb begin
    // Defaults describe the error slave.
    aw_rdy = 1'b1;
    w_rdy  = 1'b1;
    b_vld  = (aw_cnt != w_owed);
    b_rsp  = 2'b11;
    ar_rdy = 1'b1;
    r_vld  = 1'b1;
    r_rsp  = 2'b11;
    r_dat  = '0;
    for (int i = 0; i < NUM_DSTS; i++) begin
      dst_axi_awaddr[i] = src_axi_awaddr;
      dst_axi_wdata[i]  = src_axi_wdata;
      dst_axi_wstrb[i]  = src_axi_wstrb;
      dst_axi_araddr[i] = src_axi_araddr;
      dst_axi_awvalid[i] = rst_n & aw_ok &
        src_axi_awvalid & (aw_tgt == TW'(i));
      dst_axi_wvalid[i] = rst_n & w_sel &
        src_axi_wvalid & (wr_tgt == TW'(i));
      dst_axi_bready[i] = rst_n & b_sel &
        src_axi_bready & (wr_tgt == TW'(i));
      dst_axi_arvalid[i] = rst_n & ar_ok &
        src_axi_arvalid & (ar_tgt == TW'(i));
      dst_axi_rready[i] = rst_n & r_sel &
        src_axi_rready & (rd_tgt == TW'(i));
      if (aw_tgt == TW'(i))
        aw_rdy = dst_axi_awready[i];
      if (ar_tgt == TW'(i))
        ar_rdy = dst_axi_arready[i];
      if (wr_tgt == TW'(i)) begin
        w_rdy = dst_axi_wready[i];
        b_vld = dst_axi_bvalid[i];
        b_rsp = dst_axi_bresp[i];
      end
      if (rd_tgt == TW'(i)) begin
        r_vld = dst_axi_rvalid[i];
        r_rsp = dst_axi_rresp[i];
        r_dat = dst_axi_rdata[i];
      end
    end
  end

  assign src_axi_awready = rst_n & aw_ok & aw_rdy;
  assign src_axi_wready  = rst_n & w_sel & w_rdy;
  assign src_axi_bvalid  = rst_n & b_sel & b_vld;
  assign src_axi_bresp   = b_sel ? b_rsp : 2'b00;
  assign src_axi_arready = rst_n & ar_ok & ar_rdy;
  assign src_axi_rvalid  = rst_n & r_sel & r_vld;
  assign src_axi_rresp   = r_sel ? r_rsp : 2'b00;
  assign src_axi_rdata   = r_sel ? r_dat : '0;

  assign aw_hs = src_axi_awvalid & src_axi_awready;
  assign w_hs  = src_axi_wvalid  & src_axi_wready;
  assign b_hs  = src_axi_bvalid  & src_axi_bready;
  assign ar_hs = src_axi_arvalid & src_axi_arready;
  assign r_hs  = src_axi_rvalid  & src_axi_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_tgt <= '0;
      rd_tgt <= '0;
      aw_cnt <= '0;
      w_owed <= '0;
      ar_cnt <= '0;
    end else begin
      if (aw_hs)
        wr_tgt <= aw_tgt;
      if (ar_hs)
        rd_tgt <= ar_tgt;
      aw_cnt <= aw_cnt + CW'(aw_hs) - CW'(b_hs);
      w_owed <= w_owed + CW'(aw_hs) - CW'(w_hs);
      ar_cnt <= ar_cnt + CW'(ar_hs) - CW'(r_hs);
    end
  end

endmodule

// File: tb/tb_axil_split_dec.sv
// Directed bench for axil_split_dec: decode table plus
// multi-cycle sequences (ordering stalls, W-before-AW, reset).
module tb_axil_split_dec;

  localparam int ND = 2;
  localparam logic [ND-1:0][31:0] BASE = {32'h1000, 32'h0000};
  localparam logic [ND-1:0][31:0] MASK = {32'hF000, 32'hF000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready;
  logic s_bvalid, s_bready, s_arvalid, s_arready;
  logic s_rvalid, s_rready;
  logic [1:0] s_bresp, s_rresp;

  logic [ND-1:0][31:0] d_awaddr, d_wdata, d_araddr, d_rdata;
  logic [ND-1:0][3:0]  d_wstrb;
  logic [ND-1:0][1:0]  d_bresp, d_rresp;
  logic [ND-1:0] d_awvalid, d_awready, d_wvalid, d_wready;
  logic [ND-1:0] d_bvalid, d_bready, d_arvalid, d_arready;
  logic [ND-1:0] d_rvalid, d_rready;

  axil_split_dec #(
    .NUM_DSTS(ND), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .STRB_WIDTH(4), .MAX_OUTSTANDING(4),
    .DST_BASE(BASE), .DST_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_axi_awaddr(s_awaddr), .src_axi_awvalid(s_awvalid),
    .src_axi_awready(s_awready),
    .src_axi_wdata(s_wdata), .src_axi_wstrb(s_wstrb),
    .src_axi_wvalid(s_wvalid), .src_axi_wready(s_wready),
    .src_axi_bresp(s_bresp), .src_axi_bvalid(s_bvalid),
    .src_axi_bready(s_bready),
    .src_axi_araddr(s_araddr), .src_axi_arvalid(s_arvalid),
    .src_axi_arready(s_arready),
    .src_axi_rdata(s_rdata), .src_axi_rresp(s_rresp),
    .src_axi_rvalid(s_rvalid), .src_axi_rready(s_rready),
    .dst_axi_awaddr(d_awaddr), .dst_axi_awvalid(d_awvalid),
    .dst_axi_awready(d_awready),
    .dst_axi_wdata(d_wdata), .dst_axi_wstrb(d_wstrb),
    .dst_axi_wvalid(d_wvalid), .dst_axi_wready(d_wready),
    .dst_axi_bresp(d_bresp), .dst_axi_bvalid(d_bvalid),
    .dst_axi_bready(d_bready),
    .dst_axi_araddr(d_araddr), .dst_axi_arvalid(d_arvalid),
    .dst_axi_arready(d_arready),
    .dst_axi_rdata(d_rdata), .dst_axi_rresp(d_rresp),
    .dst_axi_rvalid(d_rvalid), .dst_axi_rready(d_rready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] hs_outs();
    return {s_awready, s_wready, s_bvalid, s_arready,
            s_rvalid, d_awvalid, d_wvalid, d_bready,
            d_arvalid, d_rready};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    s_awaddr = '0; s_awvalid = 0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    d_awready = '0; d_wready = '0;
    d_bvalid = '0; d_bresp = '0;
    d_arready = '0; d_rvalid = '0;
    d_rresp = '0; d_rdata = '0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  rdy;
    logic [1:0]  exp_v;
    logic        exp_r;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0004, 2'b11, 2'b01, 1'b1};
    tbl[1] = '{1'b0, 32'h0000_1FFC, 2'b11, 2'b10, 1'b1};
    tbl[2] = '{1'b0, 32'h0000_8000, 2'b00, 2'b00, 1'b1};
    tbl[3] = '{1'b0, 32'h0000_0010, 2'b10, 2'b01, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_1000, 2'b01, 2'b10, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0FFF, 2'b01, 2'b01, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_F000, 2'b00, 2'b00, 1'b1};
    tbl[7] = '{1'b1, 32'h0000_2000, 2'b11, 2'b00, 1'b1};

    // Reset holds every valid/ready low despite active inputs.
    idle();
    s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    s_arvalid = 1; s_rready = 1;
    d_awready = '1; d_wready = '1; d_bvalid = '1;
    d_arready = '1; d_rvalid = '1;
    #1;
    chk("reset_outs", hs_outs(), 15'd0);
    idle();
    step(); step();
    rst_n = 1;

    // Decode table at idle; valid is dropped before the edge.
    for (int k = 0; k < 8; k++) begin
      step();
      if (tbl[k].wr) begin
        s_awaddr = tbl[k].addr; s_awvalid = 1;
        d_awready = tbl[k].rdy;
      end else begin
        s_araddr = tbl[k].addr; s_arvalid = 1;
        d_arready = tbl[k].rdy;
      end
      #1;
      if (tbl[k].wr) begin
        chk($sformatf("tbl%0d_awvalid", k), d_awvalid, tbl[k].exp_v);
        chk($sformatf("tbl%0d_awready", k), s_awready, tbl[k].exp_r);
      end else begin
        chk($sformatf("tbl%0d_arvalid", k), d_arvalid, tbl[k].exp_v);
        chk($sformatf("tbl%0d_arready", k), s_arready, tbl[k].exp_r);
      end
      idle();
    end

    // Write 0x1004 to dst[1], AW and W both offered at once.
    step();
    s_awaddr = 32'h1004; s_awvalid = 1;
    s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF; s_wvalid = 1;
    d_awready = '1; d_wready = '1; s_bready = 1;
    #1;
    chk("w1_awvalid", d_awvalid, 2'b10);
    chk("w1_awready", s_awready, 1'b1);
    chk("w1_awaddr", d_awaddr[1], 32'h1004);
    chk("w1_wready_pre", s_wready, 1'b0);
    chk("w1_wvalid_pre", d_wvalid, 2'b00);
    step();
    s_awvalid = 0;
    #1;
    chk("w1_wready", s_wready, 1'b1);
    chk("w1_wvalid", d_wvalid, 2'b10);
    chk("w1_wdata", d_wdata[1], 32'hA5A5A5A5);
    step();
    s_wvalid = 0;
    d_bvalid = 2'b11; d_bresp[1] = 2'b00; d_bresp[0] = 2'b10;
    #1;
    chk("w1_bvalid", s_bvalid, 1'b1);
    chk("w1_bresp", s_bresp, 2'b00);
    chk("w1_bready", d_bready, 2'b10);
    step();
    #1;
    chk("w1_bvalid_done", s_bvalid, 1'b0);
    chk("w1_bready_done", d_bready, 2'b00);
    idle();

    // Unmapped read answered by the error slave.
    step();
    s_araddr = 32'h8000; s_arvalid = 1;
    d_arready = '1; d_rdata[0] = 32'hDEADBEEF;
    d_rvalid = 2'b01;
    #1;
    chk("err_arready", s_arready, 1'b1);
    chk("err_arvalid", d_arvalid, 2'b00);
    chk("err_rvalid_pre", s_rvalid, 1'b0);
    step();
    s_arvalid = 0;
    #1;
    chk("err_rvalid", s_rvalid, 1'b1);
    chk("err_rresp", s_rresp, 2'b11);
    chk("err_rdata", s_rdata, 32'h0);
    chk("err_rready", d_rready, 2'b00);
    s_rready = 1;
    step();
    #1;
    chk("err_rvalid_done", s_rvalid, 1'b0);
    idle();

    // Four reads to dst[0] fill the window; the fifth waits.
    step();
    s_araddr = 32'h0100; s_arvalid = 1; d_arready = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("r4_arready%0d", k), s_arready, 1'b1);
      step();
    end
    #1;
    chk("r4_full_arready", s_arready, 1'b0);
    chk("r4_full_arvalid", d_arvalid, 2'b00);
    step();
    d_rvalid = 2'b01; d_rdata[0] = 32'h11112222;
    s_rready = 1;
    #1;
    chk("r4_rvalid", s_rvalid, 1'b1);
    chk("r4_rdata", s_rdata, 32'h11112222);
    chk("r4_rready", d_rready, 2'b01);
    chk("r4_arready_hs", s_arready, 1'b0);
    step();
    d_rvalid = '0;
    #1;
    chk("r4_arready_free", s_arready, 1'b1);
    step();
    s_arvalid = 0;
    d_rvalid = 2'b01;
    repeat (4) step();
    #1;
    chk("r4_drained", s_rvalid, 1'b0);
    idle();

    // A read to dst[1] waits behind an outstanding dst[0] read.
    step();
    s_araddr = 32'h0000; s_arvalid = 1; d_arready = '1;
    step();
    s_araddr = 32'h1000;
    #1;
    chk("ord_arready", s_arready, 1'b0);
    chk("ord_arvalid", d_arvalid, 2'b00);
    step();
    #1;
    chk("ord_arready2", s_arready, 1'b0);
    d_rvalid = 2'b01; s_rready = 1;
    step();
    d_rvalid = '0;
    #1;
    chk("ord_arready_go", s_arready, 1'b1);
    chk("ord_arvalid_go", d_arvalid, 2'b10);
    step();
    s_arvalid = 0;
    d_rvalid = 2'b10; d_rdata[1] = 32'h33334444;
    #1;
    chk("ord_rdata", s_rdata, 32'h33334444);
    chk("ord_rready", d_rready, 2'b10);
    step();
    idle();

    // W offered two cycles ahead of its AW.
    step();
    s_wdata = 32'h5A5A0001; s_wstrb = 4'b0011; s_wvalid = 1;
    d_wready = '1; d_awready = '1; s_bready = 1;
    #1;
    chk("wb4_wready0", s_wready, 1'b0);
    step();
    #1;
    chk("wb4_wready1", s_wready, 1'b0);
    step();
    s_awaddr = 32'h0008; s_awvalid = 1;
    #1;
    chk("wb4_wready_aw", s_wready, 1'b0);
    step();
    s_awvalid = 0;
    #1;
    chk("wb4_wready", s_wready, 1'b1);
    chk("wb4_wvalid", d_wvalid, 2'b01);
    chk("wb4_wdata", d_wdata[0], 32'h5A5A0001);
    chk("wb4_wstrb", d_wstrb[0], 4'b0011);
    step();
    s_wvalid = 0; d_bvalid = 2'b01;
    step();
    idle();

    // Reset with two writes outstanding, then a clean write.
    step();
    s_awaddr = 32'h0020; s_awvalid = 1; d_awready = '1;
    step(); step();
    s_awvalid = 0; s_wvalid = 1; d_wready = '1;
    d_bvalid = 2'b01; s_bready = 1;
    s_arvalid = 1; d_arready = '1;
    #1;
    chk("rst_pre_wready", s_wready, 1'b1);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", hs_outs(), 15'd0);
    idle();
    step();
    rst_n = 1;
    step();
    s_awaddr = 32'h0030; s_awvalid = 1; d_awready = '1;
    s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_wvalid = 1;
    d_wready = '1; s_bready = 1;
    #1;
    chk("rst_aw_awvalid", d_awvalid, 2'b01);
    chk("rst_aw_wready", s_wready, 1'b0);
    step();
    s_awvalid = 0;
    #1;
    chk("rst_w_wvalid", d_wvalid, 2'b01);
    step();
    s_wvalid = 1;
    #1;
    chk("rst_w_owed0", s_wready, 1'b0);
    s_wvalid = 0;
    d_bvalid = 2'b01; d_bresp[0] = 2'b00;
    #1;
    chk("rst_bvalid", s_bvalid, 1'b1);
    step();
    #1;
    chk("rst_bdone", s_bvalid, 1'b0);
    idle();

    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_split_dec.md
Name: axil_split_dec

Overview:
- AXI-lite 1-to-N splitter with built-in address decode, replacing external one-hot decode.
- Supports multiple outstanding transactions per direction.
- Returns DECERR for unmapped addresses from an internal error slave.
- Sits between a single master (core or debug bridge) and peripheral register slaves; the forward path is zero-latency combinational, and only routing and ordering state is registered.

Parameters:
- NUM_DSTS, 4, number of destination ports (>=1).
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- MAX_OUTSTANDING, 4, max issued-but-unresponded transactions per direction (>=1).
- DST_BASE, packed [NUM_DSTS][ADDR_WIDTH], region base per destination.
- DST_MASK, packed [NUM_DSTS][ADDR_WIDTH], region compare mask per destination.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- src_axi_aw{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  source write address
- src_axi_w{data,strb,valid,ready}  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  source write data
- src_axi_b{resp,valid,ready}  out/out/in  2/1/1  source write response
- src_axi_ar{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  source read address
- src_axi_r{data,resp,valid,ready}  out/out/out/in  DATA_WIDTH/2/1/1  source read data
- dst_axi_* (same 17 signals, opposite directions)  [NUM_DSTS][width]  per-destination channels

Behaviour:
- Decode:
  - hit[i] = ((addr & DST_MASK[i]) == (DST_BASE[i] & DST_MASK[i])).
  - The lowest hit index wins.
  - No hit selects target ERR (index NUM_DSTS, the internal error slave).
- Write state:
  - wr_tgt register.
  - aw_cnt: AWs issued, B not yet returned.
  - w_owed: AWs issued whose W is not yet sent.
  - Counters are $clog2(MAX_OUTSTANDING+1) bits.
- AW issue gate: aw_ok = (aw_cnt < MAX_OUTSTANDING) & (aw_cnt==0 | tgt(awaddr)==wr_tgt).
  - Ordering is guaranteed because all outstanding writes target one destination.
  - If aw_ok and target t is real: dst_awvalid[t] = src_awvalid and src_awready = dst_awready[t].
  - If t is ERR: src_awready = 1.
  - If !aw_ok: src_awready = 0 and all dst_awvalid = 0.
  - On the AW handshake: wr_tgt <= t, aw_cnt+1, w_owed+1.
- W routing: only when w_owed != 0, to wr_tgt.
  - dst_wvalid[wr_tgt] = src_wvalid; src_wready = dst_wready[wr_tgt] (1 for ERR).
  - When w_owed == 0: src_wready = 0 (W waits for its AW; AW-before-W is permitted).
  - A W handshake decrements w_owed.
- B routing from wr_tgt when aw_cnt != 0.
  - Real target: src_bvalid/bresp from dst; dst_bready[wr_tgt] = src_bready.
  - ERR target: src_bvalid = (aw_cnt - w_owed) != 0, bresp = 2'b11.
  - A B handshake decrements aw_cnt.
- Read: same scheme with rd_tgt and ar_cnt.
  - ERR read: rvalid = ar_cnt != 0, rdata = 0, rresp = 2'b11.
  - When no read is pending: src_rdata = 0.
- Same-cycle events:
  - Issue and response together leave the counter unchanged.
  - AW+W in one cycle with w_owed==0 is not possible (W is gated by the registered w_owed). W is accepted no earlier than the cycle after AW.
- Counter limits: counters never overflow (gated at MAX_OUTSTANDING) or underflow (responses are only forwarded when the counter is nonzero).
- Spurious response: dst valid on a non-selected port is ignored; its ready stays 0.
- Outputs are never driven X; unselected dst payloads carry the src payloads.
- Reset, asynchronous and immediate:
  - Counters and tgt registers go to 0.
  - All valid and ready outputs go low; payloads are don't-care.
  - In-flight transactions are abandoned; the system resets slaves together.

Test Plan:
- NUM_DSTS=2, BASE={0x0000,0x1000}, MASK=0xF000: write 0x1004 data 0xA5A5A5A5 -> dst[1] AW/W only; bresp OKAY after dst[1] bvalid; aw_cnt returns 0.
- Read 0x8000 (unmapped) -> arready same cycle; rvalid next cycle with rresp=2'b11 and rdata=0.
- Four back-to-back reads to dst[0], rready held low -> 5th arready=0 until the first R handshake; then it issues in the same cycle the counter frees.
- Read to dst[0] outstanding, then AR to dst[1] -> stalled (arready=0, dst[1] arvalid=0) until the dst[0] R completes, then dst[1] issues.
- W presented two cycles before AW -> wready=0 until the cycle after the AW handshake; data arrives intact at the target.
- Assert rst_n low with 2 writes outstanding -> all valid and ready outputs low immediately; after release, a new write to dst[0] completes normally.
